// File: rtl/beta_regfile_if.sv
// beta_regfile_if: bus bundle between the Beta datapath control and the
// register file.
//   master : drives read/write requests (rd_en, addresses, ra2sel, we, wa, wd)
//            and receives the registered read results (ra_data, rb_data, z)
//   slave  : the register file side of the same bundle
interface beta_regfile_if #(
  parameter int WIDTH = 32
);
  logic             rd_en;
  logic [4:0]       ra_addr;
  logic [4:0]       rb_addr;
  logic [4:0]       rc_addr;
  logic             ra2sel;
  logic             we;
  logic [4:0]       wa;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] ra_data;
  logic [WIDTH-1:0] rb_data;
  logic             z;

  modport master (
    output rd_en, ra_addr, rb_addr, rc_addr, ra2sel, we, wa, wd,
    input  ra_data, rb_data, z
  );

  modport slave (
    input  rd_en, ra_addr, rb_addr, rc_addr, ra2sel, we, wa, wd,
    output ra_data, rb_data, z
  );
endinterface

// File: rtl/beta_regfile.sv
// beta_regfile: 32 x WIDTH register file for the Beta datapath.
// Two registered read ports (A -> ALU operand A, B -> operand B / store data)
// and one write port fed by the write-back mux. Register 31 always reads 0.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears storage and read outputs)
//   rf    : beta_regfile_if.slave bundle
//           rd_en            capture new read data (0 = hold / stall)
//           ra_addr          port A address
//           rb_addr/rc_addr  port B address, chosen by ra2sel (1 = rc_addr)
//           we, wa, wd       write port
//           ra_data, rb_data registered read data
//           z                registered flag, 1 when ra_data is zero
module beta_regfile #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  beta_regfile_if.slave rf
);

  localparam logic [4:0] ZERO_REG = 5'd31;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [4:0]       rb_sel;
  logic [WIDTH-1:0] ra_val;
  logic [WIDTH-1:0] rb_val;

  logic [WIDTH-1:0] ra_data_p1;
  logic [WIDTH-1:0] rb_data_p1;
  logic             z_p1;

  // Read value for one port: R31 is hardwired zero (even against a same-edge
  // write to 31), otherwise a same-edge write wins over the stored entry.
  function automatic logic [WIDTH-1:0] rd_port(
    input logic [4:0]       addr,
    input logic [WIDTH-1:0] stored,
    input logic             wr_en,
    input logic [4:0]       wr_addr,
    input logic [WIDTH-1:0] wr_data
  );
    logic [WIDTH-1:0] val;
    if (addr == ZERO_REG) begin
      val = '0;
    end else if (wr_en && (wr_addr == addr)) begin
      val = wr_data;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  always_comb begin
    rb_sel = rf.ra2sel ? rf.rc_addr : rf.rb_addr;
    ra_val = rd_port(rf.ra_addr, mem[rf.ra_addr], rf.we, rf.wa, rf.wd);
    rb_val = rd_port(rb_sel, mem[rb_sel], rf.we, rf.wa, rf.wd);
  end

  // Storage; writes to R31 are dropped so the entry itself stays 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (rf.we && (rf.wa != ZERO_REG)) begin
      mem[rf.wa] <= rf.wd;
    end
  end

  // ---- stage boundary: read capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_data_p1 <= '0;
      rb_data_p1 <= '0;
      z_p1       <= 1'b1;
    end else if (rf.rd_en) begin
      ra_data_p1 <= ra_val;
      rb_data_p1 <= rb_val;
      z_p1       <= (ra_val == '0);
    end
  end

  assign rf.ra_data = ra_data_p1;
  assign rf.rb_data = rb_data_p1;
  assign rf.z       = z_p1;

endmodule
